// File: rtl/store_queue_pkg.sv
// rtl/store_queue_pkg.sv - shared types and constants for the store queue
package store_queue_pkg;

    localparam int SQ_DEPTH_DEF = 8;
    localparam int SQ_IDX_W_DEF = $clog2(SQ_DEPTH_DEF);
    localparam int B_MASK_W     = 4;
    localparam int BYTE_MASK_W  = 4;

    typedef logic [B_MASK_W-1:0]     B_MASK;
    typedef logic [BYTE_MASK_W-1:0]  BYTE_MASK;
    typedef logic [SQ_IDX_W_DEF-1:0] SQ_IDX;

    typedef enum logic [1:0] {
        SQ_EMPTY  = 2'd0,
        SQ_ALLOC  = 2'd1,
        SQ_READY  = 2'd2,
        SQ_COMMIT = 2'd3
    } SQ_STATE;

    typedef struct packed {
        SQ_STATE     state;
        logic [31:0] addr;
        logic [31:0] data;
        BYTE_MASK    byte_mask;
        B_MASK       bm;
    } SQ_ENTRY;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] result;
        BYTE_MASK    byte_mask;
        B_MASK       bm;
    } STORE_QUEUE_PACKET;

endpackage

// File: rtl/store_queue_squash_tail.sv
// rtl/store_queue_squash_tail.sv - oldest squashed entry search in age order
module sq_squash_tail #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] squash,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] probe;

    // Walk the ring from the oldest uncommitted entry; the first hit is the oldest squashed store.
    // Squashable entries only live between start and tail, so a full lap is equivalent to stopping at tail.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        probe = start;
        for (int i = 0; i < DEPTH; i++) begin
            probe = start + IDX_W'(i);
            if (!found && squash[probe]) begin
                found = 1'b1;
                idx   = probe;
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// rtl/store_queue.sv - circular store buffer with commit, drain and branch squash
module store_queue
    import store_queue_pkg::*;
#(
    parameter int SQ_DEPTH = 8,
    parameter int SQ_IDX_W = $clog2(SQ_DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alloc_valid,
    input  B_MASK               alloc_bm,
    output logic                alloc_ready,
    output logic [SQ_IDX_W-1:0] alloc_idx,
    input  STORE_QUEUE_PACKET   fill_packet,
    input  logic [SQ_IDX_W-1:0] fill_idx,
    input  B_MASK               b_mm_resolve,
    input  logic                b_mm_mispred,
    input  logic                retire_valid,
    output logic                dc_req_valid,
    output logic [31:0]         dc_req_addr,
    output logic [31:0]         dc_req_data,
    output BYTE_MASK            dc_req_byte_mask,
    input  logic                dc_req_ready,
    output logic                sq_full,
    output logic                sq_empty
);

    localparam logic [SQ_IDX_W-1:0] IDX_ONE = SQ_IDX_W'(1);
    localparam logic [SQ_IDX_W:0]   CNT_ONE = (SQ_IDX_W + 1)'(1);
    localparam logic [SQ_IDX_W:0]   CNT_MAX = (SQ_IDX_W + 1)'(SQ_DEPTH);

    SQ_ENTRY               entries [SQ_DEPTH];
    logic [SQ_IDX_W-1:0]   head;
    logic [SQ_IDX_W-1:0]   commit_ptr;
    logic [SQ_IDX_W-1:0]   tail;
    logic [SQ_IDX_W:0]     count;

    logic [SQ_DEPTH-1:0]   squash_vec;
    logic [SQ_IDX_W-1:0]   squash_idx;
    logic                  squash_found;
    logic                  mispred;
    logic                  resolve_ok;
    logic                  drain;
    logic                  grant;
    logic                  fill_hit;
    B_MASK                 alloc_bm_eff;
    B_MASK                 fill_bm_eff;
    logic [SQ_IDX_W-1:0]   head_next;
    logic [SQ_IDX_W-1:0]   tail_base;

    assign sq_full          = (count == CNT_MAX);
    assign sq_empty         = (count == '0);
    assign alloc_ready      = !sq_full;
    assign alloc_idx        = tail;
    assign dc_req_valid     = (entries[head].state == SQ_COMMIT);
    assign dc_req_addr      = entries[head].addr;
    assign dc_req_data      = entries[head].data;
    assign dc_req_byte_mask = entries[head].byte_mask;

    sq_squash_tail #(
        .DEPTH (SQ_DEPTH),
        .IDX_W (SQ_IDX_W)
    ) u_squash_tail (
        .squash (squash_vec),
        .start  (commit_ptr),
        .idx    (squash_idx),
        .found  (squash_found)
    );

    // Per-cycle event decode: squash candidates, handshakes and branch-cleaned masks.
    always_comb begin
        mispred      = b_mm_mispred && (b_mm_resolve != '0);
        resolve_ok   = !b_mm_mispred && (b_mm_resolve != '0);
        alloc_bm_eff = resolve_ok ? (alloc_bm & ~b_mm_resolve) : alloc_bm;
        fill_bm_eff  = resolve_ok ? (fill_packet.bm & ~b_mm_resolve) : fill_packet.bm;
        squash_vec   = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            squash_vec[i] = mispred
                         && ((entries[i].state == SQ_ALLOC) || (entries[i].state == SQ_READY))
                         && ((entries[i].bm & b_mm_resolve) != '0);
        end
        drain     = dc_req_valid && dc_req_ready;
        // Squash is applied before allocation, so a store on the wrong path is simply not granted.
        grant     = alloc_valid && alloc_ready && !(mispred && ((alloc_bm & b_mm_resolve) != '0));
        fill_hit  = fill_packet.valid && (entries[fill_idx].state == SQ_ALLOC) && !squash_vec[fill_idx];
        head_next = drain ? (head + IDX_ONE) : head;
        tail_base = squash_found ? squash_idx : tail;
    end

    // Entry state machines and ring pointers; allocation is last so it may reuse a just-squashed slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries[i] <= '{state: SQ_EMPTY, addr: '0, data: '0, byte_mask: '0, bm: '0};
            end
            head       <= '0;
            commit_ptr <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (squash_vec[i]) begin
                    entries[i].state <= SQ_EMPTY;
                    entries[i].bm    <= '0;
                end else begin
                    if (resolve_ok) begin
                        entries[i].bm <= entries[i].bm & ~b_mm_resolve;
                    end
                    if (fill_hit && (fill_idx == SQ_IDX_W'(i))) begin
                        entries[i].state     <= SQ_READY;
                        entries[i].addr      <= fill_packet.addr;
                        entries[i].data      <= fill_packet.result;
                        entries[i].byte_mask <= fill_packet.byte_mask;
                        entries[i].bm        <= fill_bm_eff;
                    end
                    if (retire_valid && (commit_ptr == SQ_IDX_W'(i))) begin
                        entries[i].state <= SQ_COMMIT;
                    end
                    if (drain && (head == SQ_IDX_W'(i))) begin
                        entries[i].state <= SQ_EMPTY;
                    end
                end
                if (grant && (tail_base == SQ_IDX_W'(i))) begin
                    entries[i].state <= SQ_ALLOC;
                    entries[i].bm    <= alloc_bm_eff;
                end
            end

            head       <= head_next;
            commit_ptr <= retire_valid ? (commit_ptr + IDX_ONE) : commit_ptr;
            tail       <= grant ? (tail_base + IDX_ONE) : tail_base;

            // A squash always frees at least one slot, so tail - head never aliases the full case here.
            if (squash_found) begin
                count <= {1'b0, tail_base - head_next} + (grant ? CNT_ONE : '0);
            end else begin
                count <= count + (grant ? CNT_ONE : '0) - (drain ? CNT_ONE : '0);
            end
        end
    end

    // Protocol checks on the retire and fill interfaces.
    always @(posedge clock) begin
        if (reset) begin
            if (retire_valid) begin
                assert ((entries[commit_ptr].state == SQ_READY) && (entries[commit_ptr].bm == '0))
                    else $error("store_queue: retire of a store that is not ready or still speculative");
            end
            if (fill_packet.valid && !squash_vec[fill_idx]) begin
                assert (entries[fill_idx].state == SQ_ALLOC)
                    else $error("store_queue: fill targets an entry that is not allocated");
            end
        end
    end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Circular store buffer. It consumes the STORE_QUEUE_PACKET produced by the store address stage and holds stores in program order.
- On ROB retirement it marks stores committed, then drains them one at a time to the D-cache through a valid/ready write port.
- It tracks branch masks so that mispredicted stores are squashed before they can commit.

Parameters:
- SQ_DEPTH, 8, number of entries; must be a power of two ≥ 2.
- SQ_IDX_W, $clog2(SQ_DEPTH), entry index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- alloc_valid  in  1  dispatch requests one store entry.
- alloc_bm  in  B_MASK  branch mask of the dispatching store.
- alloc_ready  out  1  entry available; equals !sq_full.
- alloc_idx  out  SQ_IDX_W  current tail; the index granted when alloc_valid && alloc_ready.
- fill_packet  in  STORE_QUEUE_PACKET  address/data/byte_mask/bm from the store address stage.
- fill_idx  in  SQ_IDX_W  target entry of fill_packet.
- b_mm_resolve  in  B_MASK  one-hot branch resolving this cycle (0 = none).
- b_mm_mispred  in  1  the resolving branch was mispredicted.
- retire_valid  in  1  ROB retires the oldest uncommitted store.
- dc_req_valid  out  1  write request to D-cache.
- dc_req_addr  out  32  store address.
- dc_req_data  out  32  store data.
- dc_req_byte_mask  out  BYTE_MASK  byte enables.
- dc_req_ready  in  1  D-cache accepts the request.
- sq_full  out  1  count == SQ_DEPTH.
- sq_empty  out  1  count == 0.

Behaviour:

Entry states (per-entry FSM):
- SQ_EMPTY → SQ_ALLOC on allocate.
- SQ_ALLOC → SQ_READY on fill.
- SQ_READY → SQ_COMMIT on retire.
- SQ_COMMIT → SQ_EMPTY on drain handshake.
- SQ_ALLOC / SQ_READY → SQ_EMPTY on squash.

Pointers:
- head (oldest), commit_ptr (oldest uncommitted), tail (next free).
- count has width SQ_IDX_W+1.
- Pointers wrap modulo SQ_DEPTH.

Reset (reset==0, asynchronous):
- All entries go to SQ_EMPTY with bm=0.
- head = commit_ptr = tail = 0, count = 0.
- Outputs: dc_req_valid=0, sq_empty=1, sq_full=0, alloc_ready=1, alloc_idx=0.
- Reset mid-drain discards all entries, committed ones included.

Allocate:
- When alloc_valid && alloc_ready: entry[tail] takes state SQ_ALLOC and bm=alloc_bm; tail++ and count++ at the clock edge.
- alloc_ready is low when full, even if a drain completes in the same cycle. There is no same-cycle bypass.

Fill:
- When fill_packet.valid, entry[fill_idx] latches addr/result/byte_mask/bm and goes to SQ_READY.
- Fill to an entry not in SQ_ALLOC is a protocol error and is flagged by an assertion.

Retire:
- When retire_valid: entry[commit_ptr] goes to SQ_COMMIT and commit_ptr++.
- The entry must already be SQ_READY with bm==0; otherwise an assertion fires.

Drain:
- dc_req_valid = (entry[head].state == SQ_COMMIT).
- Address, data and mask outputs come combinationally from entry[head].
- When dc_req_valid && dc_req_ready: entry goes to SQ_EMPTY, head++, count--.
- Once asserted, dc_req_valid and the payload stay stable until the handshake completes.
- At most one drain per cycle.

Branch resolve, correct prediction (b_mm_resolve≠0, !b_mm_mispred):
- Clear that bit in every live entry's bm, in the incoming fill_packet.bm, and in alloc_bm.

Branch mispredict:
- Every SQ_ALLOC/SQ_READY entry with (bm & b_mm_resolve)≠0 goes to SQ_EMPTY.
- tail = index of the oldest squashed entry, searching from commit_ptr toward tail.
- count is recomputed as tail−head, modulo, with the full case handled.
- A same-cycle allocation whose alloc_bm contains the bit is dropped.
- A same-cycle fill targeting a squashed entry is ignored.
- Committed entries (bm==0) are never squashed, so draining continues unaffected.

Simultaneous events:
- Allocate + drain in the same cycle: count unchanged.
- Allocate + mispredict: squash is applied first, then the allocation is granted only if its bm survives; tail = new tail + 1.
- Retire + drain of the same entry cannot occur, because the entry needs to be SQ_COMMIT before the cycle.

Latency:
- Fill → retire-eligible: 1 cycle.
- Retire → dc_req_valid: 1 cycle, when at head.

Decomposition:
- Shared package (sys_defs.svh):
  - SQ_STATE enum {SQ_EMPTY, SQ_ALLOC, SQ_READY, SQ_COMMIT}.
  - SQ_ENTRY struct {state, addr, data, byte_mask, bm}.
  - SQ_DEPTH constant and SQ_IDX typedef.
  - STORE_QUEUE_PACKET, B_MASK and BYTE_MASK are reused as already defined.
- Sub-module:
  - sq_squash_tail: combinational age-ordered search returning the oldest squashed index plus a found flag.
  - All other logic stays in store_queue.

Test Plan:
1. Reset low mid-operation with 3 entries → sq_empty=1, dc_req_valid=0, alloc_idx=0 immediately (asynchronous reset).
2. Allocate 8 stores with bm=0 → sq_full=1, alloc_ready=0; a 9th alloc_valid is ignored and tail stays 0.
3. Alloc idx0, then fill {addr=0x1004, result=0xDEADBEEF, byte_mask=4'b0011}, then retire, with dc_req_ready=0 for 2 cycles then 1 → dc_req_valid high 1 cycle after retire, payload stable across the stalled cycles, handshake empties the queue.
4. Alloc idx0 bm=0, idx1 bm=0010, idx2 bm=0010; then b_mm_resolve=0010 with mispred → idx1–2 squashed, tail=1, count=1, idx0 unaffected.
5. Same setup as scenario 4 but without mispred → idx1/idx2 bm becomes 0; both retire and drain in order idx1 then idx2.
6. Wrap: alloc/retire/drain 10 stores one at a time → alloc_idx sequence 0..7,0,1; dc_req_addr order matches program order.
